// File: rtl/fifo_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_pkg
// Description : Shared defaults and types for the synchronous FIFO. The
//               defaults apply to every FIFO instance placed around the
//               4-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_sync_pkg;

  // Default geometry for all FIFO instances.
  localparam int FIFO_WORD_SIZE_DEF = 10;
  localparam int ADDR_WIDTH_DEF     = 3;

  // Occupancy status flags, grouped so they can be produced in one place.
  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // Number of entries for a given pointer width.
  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mem
// Description : DEPTH x W register array with one write port and one
//               registered read port. Array contents are never reset. Only
//               the read register is reset.
// Ports       : clk, reset_L         - clock, synchronous active-low reset
//               we, waddr, wdata     - write port
//               re, raddr            - read request and address
//               rdata                - registered read data, holds when !re
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem
  import fifo_sync_pkg::*;
#(
  parameter int FIFO_WORD_SIZE = FIFO_WORD_SIZE_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic                      we,
  input  logic [ADDR_WIDTH-1:0]     waddr,
  input  logic [FIFO_WORD_SIZE-1:0] wdata,
  input  logic                      re,
  input  logic [ADDR_WIDTH-1:0]     raddr,
  output logic [FIFO_WORD_SIZE-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [FIFO_WORD_SIZE-1:0] mem_q [DEPTH];
  logic [FIFO_WORD_SIZE-1:0] rdata_q;

  // Storage array. It has no reset, so it maps onto plain registers or RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/fifo_sync.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync
// Description : Synchronous FIFO with programmable almost-full/almost-empty
//               thresholds and a sticky overflow/underflow error flag.
// Ports       : clk, reset_L          - clock, synchronous active-low reset
//               push, data_in         - write enable and data
//               pop                   - read enable
//               umbral_af, umbral_ae  - occupancy thresholds (AW+1 bits)
//               data_out, valid_out   - registered read data and its strobe
//               empty, full           - occupancy == 0 / == DEPTH
//               almost_full           - occupancy >= umbral_af
//               almost_empty          - occupancy <= umbral_ae
//               error                 - sticky overflow/underflow
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync
  import fifo_sync_pkg::*;
#(
  parameter int FIFO_WORD_SIZE = FIFO_WORD_SIZE_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic                      push,
  input  logic                      pop,
  input  logic [FIFO_WORD_SIZE-1:0] data_in,
  input  logic [ADDR_WIDTH:0]       umbral_af,
  input  logic [ADDR_WIDTH:0]       umbral_ae,
  output logic [FIFO_WORD_SIZE-1:0] data_out,
  output logic                      valid_out,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      error
);

  localparam int                  DEPTH    = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,  count_d;
  logic                  valid_q,  valid_d;
  logic                  error_q,  error_d;

  fifo_flags_t flags;
  logic        push_acc;
  logic        pop_acc;
  logic        overflow;
  logic        underflow;

  // Flags depend only on the registered count and the live thresholds.
  // A threshold above DEPTH can never be reached, so almost_full stays low.
  always_comb begin
    flags              = '0;
    flags.empty        = (count_q == '0);
    flags.full         = (count_q == FULL_CNT);
    flags.almost_full  = (count_q >= umbral_af);
    flags.almost_empty = (count_q <= umbral_ae);
  end

  // A full FIFO still takes a push when a pop frees a slot in the same cycle.
  // An empty FIFO never forwards the incoming word to the read side.
  assign pop_acc   = pop && !flags.empty;
  assign push_acc  = push && (!flags.full || pop_acc);
  assign overflow  = push && flags.full && !pop;
  assign underflow = pop && flags.empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = pop_acc;
    error_d  = error_q || overflow || underflow;
    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  // The enables are gated with reset so a held reset never writes the array.
  fifo_mem #(
    .FIFO_WORD_SIZE (FIFO_WORD_SIZE),
    .ADDR_WIDTH     (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .reset_L (reset_L),
    .we      (push_acc && reset_L),
    .waddr   (wr_ptr_q),
    .wdata   (data_in),
    .re      (pop_acc && reset_L),
    .raddr   (rd_ptr_q),
    .rdata   (data_out)
  );

  assign valid_out    = valid_q;
  assign error        = error_q;
  assign empty        = flags.empty;
  assign full         = flags.full;
  assign almost_full  = flags.almost_full;
  assign almost_empty = flags.almost_empty;

endmodule
`default_nettype wire
